// File: rtl/t48_xbus_responder_if.sv
// Bus bundle between the T48 core pins, the external-memory responder and the ROM/RAM models.
// The responder uses the slave view; the core/board side uses the master view.
interface t48_xbus_responder_if;
  logic        ale_i;
  logic        psen_n_i;
  logic        rd_n_i;
  logic        wr_n_i;
  logic [7:0]  db_i;
  logic        db_dir_i;
  logic [3:0]  p2_i;
  logic [7:0]  db_o;
  logic        db_dir_o;
  logic [11:0] rom_addr_o;
  logic        rom_rd_o;
  logic [7:0]  rom_data_i;
  logic [7:0]  ram_addr_o;
  logic        ram_rd_o;
  logic [7:0]  ram_data_i;
  logic        ram_we_o;
  logic [7:0]  ram_data_o;
  logic        err_o;

  modport slave (
    input  ale_i, psen_n_i, rd_n_i, wr_n_i, db_i, db_dir_i, p2_i, rom_data_i, ram_data_i,
    output db_o, db_dir_o, rom_addr_o, rom_rd_o, ram_addr_o, ram_rd_o, ram_we_o, ram_data_o,
           err_o
  );

  modport master (
    output ale_i, psen_n_i, rd_n_i, wr_n_i, db_i, db_dir_i, p2_i, rom_data_i, ram_data_i,
    input  db_o, db_dir_o, rom_addr_o, rom_rd_o, ram_addr_o, ram_rd_o, ram_we_o, ram_data_o,
           err_o
  );
endinterface

// File: rtl/t48_xbus_responder.sv
// External-memory responder for the T48 multiplexed DB bus: latches the address on ALE fall,
// serves PSEN fetches from ROM and MOVX reads/writes from/to RAM, drives DB only during reads.
module t48_xbus_responder #(
  parameter int unsigned ROM_LAT = 1,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic                  clk_i,
  input  logic                  res_i,
  t48_xbus_responder_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StWait, StDrive, StWrite} state_e;
  typedef enum logic {KindFetch, KindRead} kind_e;

  localparam logic [2:0] RomLat = 3'(ROM_LAT);
  localparam logic [2:0] RamLat = 3'(RAM_LAT);

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ale_q, psen_q, rd_q, wr_q;
  logic [7:0]  addr_lo_q, addr_lo_d;
  logic [3:0]  addr_hi_q, addr_hi_d;
  logic [7:0]  db_q, db_d;
  logic        db_dir_q, db_dir_d;
  logic        rom_rd_q, rom_rd_d;
  logic        ram_rd_q, ram_rd_d;
  logic        ram_we_q, ram_we_d;
  logic [7:0]  ram_data_q, ram_data_d;
  logic        err_q, err_d;

  logic       ale_fall, psen_fall, rd_fall, wr_fall;
  logic [1:0] n_low;
  logic       sel_high, other_fall, conflict;

  always_comb begin
    ale_fall  = ale_q & ~bus.ale_i;
    psen_fall = psen_q & ~bus.psen_n_i;
    rd_fall   = rd_q & ~bus.rd_n_i;
    wr_fall   = wr_q & ~bus.wr_n_i;
    n_low     = {1'b0, ~bus.psen_n_i} + {1'b0, ~bus.rd_n_i} + {1'b0, ~bus.wr_n_i};
    sel_high  = (kind_q == KindFetch) ? bus.psen_n_i : bus.rd_n_i;
    // A fall on any strobe other than the one owning the current cycle is a protocol error.
    other_fall = (kind_q == KindFetch) ? (rd_fall | wr_fall) : (psen_fall | wr_fall);
    conflict  = db_dir_q & bus.db_dir_i;
  end

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    cnt_d      = cnt_q;
    addr_lo_d  = addr_lo_q;
    addr_hi_d  = addr_hi_q;
    db_d       = db_q;
    db_dir_d   = db_dir_q;
    rom_rd_d   = 1'b0;
    ram_rd_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_data_d = ram_data_q;
    err_d      = err_q;

    if (ale_fall) begin
      addr_lo_d = bus.db_i;
      addr_hi_d = bus.p2_i;
    end

    case (state_q)
      StIdle: begin
        if (n_low >= 2'd2) begin
          err_d = 1'b1;
        end else if (psen_fall) begin
          rom_rd_d = 1'b1;
          cnt_d    = RomLat;
          kind_d   = KindFetch;
          state_d  = StWait;
        end else if (rd_fall) begin
          ram_rd_d = 1'b1;
          cnt_d    = RamLat;
          kind_d   = KindRead;
          state_d  = StWait;
        end else if (wr_fall) begin
          ram_data_d = bus.db_i;
          state_d    = StWrite;
        end
      end
      StWait: begin
        if (other_fall) err_d = 1'b1;
        cnt_d = cnt_q - 3'd1;
        if (sel_high) begin
          state_d = StIdle;
        end else if (cnt_q <= 3'd1) begin
          db_d     = (kind_q == KindFetch) ? bus.rom_data_i : bus.ram_data_i;
          db_dir_d = 1'b1;
          state_d  = StDrive;
        end
      end
      StDrive: begin
        if (other_fall || conflict) err_d = 1'b1;
        if (sel_high || conflict) begin
          db_dir_d = 1'b0;
          db_d     = 8'hFF;
        end
        if (sel_high) state_d = StIdle;
      end
      StWrite: begin
        if (psen_fall || rd_fall) err_d = 1'b1;
        if (!bus.wr_n_i) begin
          ram_data_d = bus.db_i;
        end else begin
          ram_we_d = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state_q    <= StIdle;
      kind_q     <= KindFetch;
      cnt_q      <= 3'd0;
      ale_q      <= 1'b0;
      psen_q     <= 1'b1;
      rd_q       <= 1'b1;
      wr_q       <= 1'b1;
      addr_lo_q  <= 8'h00;
      addr_hi_q  <= 4'h0;
      db_q       <= 8'hFF;
      db_dir_q   <= 1'b0;
      rom_rd_q   <= 1'b0;
      ram_rd_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_data_q <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      cnt_q      <= cnt_d;
      ale_q      <= bus.ale_i;
      psen_q     <= bus.psen_n_i;
      rd_q       <= bus.rd_n_i;
      wr_q       <= bus.wr_n_i;
      addr_lo_q  <= addr_lo_d;
      addr_hi_q  <= addr_hi_d;
      db_q       <= db_d;
      db_dir_q   <= db_dir_d;
      rom_rd_q   <= rom_rd_d;
      ram_rd_q   <= ram_rd_d;
      ram_we_q   <= ram_we_d;
      ram_data_q <= ram_data_d;
      err_q      <= err_d;
    end
  end

  assign bus.db_o       = db_q;
  assign bus.db_dir_o   = db_dir_q;
  assign bus.rom_addr_o = {addr_hi_q, addr_lo_q};
  assign bus.ram_addr_o = addr_lo_q;
  assign bus.rom_rd_o   = rom_rd_q;
  assign bus.ram_rd_o   = ram_rd_q;
  assign bus.ram_we_o   = ram_we_q;
  assign bus.ram_data_o = ram_data_q;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_t48_xbus_responder.sv
// Directed bench: stimulus pushes expected bus events into a scoreboard queue and a
// negedge monitor pops and compares them; a second instance with ROM_LAT=4 covers abort.
module tb_t48_xbus_responder;

  typedef enum int {EvRomRd, EvRamRd, EvDrive, EvWe} ev_e;
  typedef struct {
    ev_e         ev;
    logic [11:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic clk;
  logic res;
  int   n_vec;
  int   n_err;
  exp_t sb[$];
  logic prev_dir;

  t48_xbus_responder_if bus ();
  t48_xbus_responder_if bus4 ();

  t48_xbus_responder #(.ROM_LAT(1), .RAM_LAT(3)) dut (
    .clk_i (clk),
    .res_i (res),
    .bus   (bus.slave)
  );

  t48_xbus_responder #(.ROM_LAT(4), .RAM_LAT(3)) dut4 (
    .clk_i (clk),
    .res_i (res),
    .bus   (bus4.slave)
  );

  assign bus4.ale_i      = bus.ale_i;
  assign bus4.psen_n_i   = bus.psen_n_i;
  assign bus4.rd_n_i     = bus.rd_n_i;
  assign bus4.wr_n_i     = bus.wr_n_i;
  assign bus4.db_i       = bus.db_i;
  assign bus4.db_dir_i   = bus.db_dir_i;
  assign bus4.p2_i       = bus.p2_i;
  assign bus4.rom_data_i = bus.rom_data_i;
  assign bus4.ram_data_i = bus.ram_data_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input ev_e ev, input logic [11:0] addr, input logic [7:0] data);
    exp_t e;
    e.ev   = ev;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic got(input ev_e ev, input logic [11:0] addr, input logic [7:0] data);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got ev=%0d addr=%0h data=%0h, none expected", ev, addr,
               data);
    end else begin
      e = sb.pop_front();
      if (e.ev != ev || e.addr !== addr || e.data !== data) begin
        n_err++;
        $display("FAIL event: got ev=%0d addr=%0h data=%0h expected ev=%0d addr=%0h data=%0h",
                 ev, addr, data, e.ev, e.addr, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!res) begin
      if (bus.rom_rd_o) got(EvRomRd, bus.rom_addr_o, 8'h00);
      if (bus.ram_rd_o) got(EvRamRd, {4'h0, bus.ram_addr_o}, 8'h00);
      if (bus.db_dir_o && !prev_dir) got(EvDrive, 12'h000, bus.db_o);
      if (bus.ram_we_o) got(EvWe, {4'h0, bus.ram_addr_o}, bus.ram_data_o);
    end
    prev_dir <= bus.db_dir_o;
  end

  task automatic latch(input logic [7:0] lo, input logic [3:0] hi);
    bus.ale_i    = 1'b1;
    bus.db_i     = lo;
    bus.p2_i     = hi;
    bus.db_dir_i = 1'b1;
    @(negedge clk);
    bus.ale_i = 1'b0;
    @(negedge clk);
    bus.db_dir_i = 1'b0;
    bus.db_i     = 8'hFF;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    prev_dir = 1'b0;
    res = 1'b1;
    bus.ale_i      = 1'b0;
    bus.psen_n_i   = 1'b1;
    bus.rd_n_i     = 1'b1;
    bus.wr_n_i     = 1'b1;
    bus.db_i       = 8'hFF;
    bus.db_dir_i   = 1'b0;
    bus.p2_i       = 4'h0;
    bus.rom_data_i = 8'h5C;
    bus.ram_data_i = 8'hC3;
    repeat (2) @(negedge clk);
    chk("rst_db_o", {4'h0, bus.db_o}, 12'h0FF);
    chk("rst_db_dir", {11'h0, bus.db_dir_o}, 12'h0);
    chk("rst_rom_addr", bus.rom_addr_o, 12'h000);
    chk("rst_ram_addr", {4'h0, bus.ram_addr_o}, 12'h000);
    chk("rst_pulses", {9'h0, bus.rom_rd_o, bus.ram_rd_o, bus.ram_we_o}, 12'h0);
    chk("rst_ram_data", {4'h0, bus.ram_data_o}, 12'h000);
    chk("rst_err", {11'h0, bus.err_o}, 12'h0);
    res = 1'b0;
    @(negedge clk);

    // Fetch, ROM_LAT=1, PSEN low for 4 edges.
    latch(8'h34, 4'hA);
    chk("fetch_rom_addr", bus.rom_addr_o, 12'hA34);
    push(EvRomRd, 12'hA34, 8'h00);
    push(EvDrive, 12'h000, 8'h5C);
    bus.psen_n_i = 1'b0;
    @(negedge clk);
    chk("fetch_dir_e0", {11'h0, bus.db_dir_o}, 12'h0);
    @(negedge clk);
    chk("fetch_dir_e1", {11'h0, bus.db_dir_o}, 12'h1);
    chk("fetch_db_e1", {4'h0, bus.db_o}, 12'h05C);
    @(negedge clk);
    @(negedge clk);
    chk("fetch_dir_e3", {11'h0, bus.db_dir_o}, 12'h1);
    bus.psen_n_i = 1'b1;
    @(negedge clk);
    chk("fetch_release_dir", {11'h0, bus.db_dir_o}, 12'h0);
    chk("fetch_release_db", {4'h0, bus.db_o}, 12'h0FF);
    chk("fetch_err", {11'h0, bus.err_o}, 12'h0);

    // MOVX read, RAM_LAT=3, RD low for 5 edges.
    latch(8'h80, 4'h0);
    chk("read_ram_addr", {4'h0, bus.ram_addr_o}, 12'h080);
    push(EvRamRd, 12'h080, 8'h00);
    push(EvDrive, 12'h000, 8'hC3);
    bus.rd_n_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("read_dir_e2", {11'h0, bus.db_dir_o}, 12'h0);
    @(negedge clk);
    chk("read_dir_e3", {11'h0, bus.db_dir_o}, 12'h1);
    chk("read_db_e3", {4'h0, bus.db_o}, 12'h0C3);
    @(negedge clk);
    bus.rd_n_i = 1'b1;
    @(negedge clk);
    chk("read_release_dir", {11'h0, bus.db_dir_o}, 12'h0);

    // MOVX write, WR low for 3 edges, last sampled data wins.
    latch(8'h10, 4'h0);
    push(EvWe, 12'h010, 8'h77);
    bus.wr_n_i   = 1'b0;
    bus.db_dir_i = 1'b1;
    bus.db_i     = 8'h11;
    @(negedge clk);
    bus.db_i = 8'h22;
    @(negedge clk);
    bus.db_i = 8'h77;
    @(negedge clk);
    chk("write_we_low", {11'h0, bus.ram_we_o}, 12'h0);
    bus.wr_n_i = 1'b1;
    bus.db_i   = 8'hFF;
    @(negedge clk);
    chk("write_we_pulse", {11'h0, bus.ram_we_o}, 12'h1);
    chk("write_data", {4'h0, bus.ram_data_o}, 12'h077);
    bus.db_dir_i = 1'b0;
    @(negedge clk);
    chk("write_we_single", {11'h0, bus.ram_we_o}, 12'h0);
    chk("write_dir", {11'h0, bus.db_dir_o}, 12'h0);

    // Abort: PSEN low 2 edges; the ROM_LAT=4 instance must never drive.
    latch(8'h55, 4'h3);
    push(EvRomRd, 12'h355, 8'h00);
    push(EvDrive, 12'h000, 8'h5C);
    bus.psen_n_i = 1'b0;
    @(negedge clk);
    chk("abort_dir_e0", {11'h0, bus4.db_dir_o}, 12'h0);
    @(negedge clk);
    bus.psen_n_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_dir", {11'h0, bus4.db_dir_o}, 12'h0);
    end
    chk("abort_err", {11'h0, bus4.err_o}, 12'h0);
    chk("abort_err_lat1", {11'h0, bus.err_o}, 12'h0);

    // Conflict: core drives DB while the responder drives.
    latch(8'h21, 4'h1);
    push(EvRomRd, 12'h121, 8'h00);
    push(EvDrive, 12'h000, 8'h5C);
    bus.psen_n_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("conf_dir_before", {11'h0, bus.db_dir_o}, 12'h1);
    bus.db_dir_i = 1'b1;
    @(negedge clk);
    chk("conf_dir_forced", {11'h0, bus.db_dir_o}, 12'h0);
    chk("conf_db", {4'h0, bus.db_o}, 12'h0FF);
    chk("conf_err", {11'h0, bus.err_o}, 12'h1);
    bus.db_dir_i = 1'b0;
    bus.psen_n_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("conf_err_sticky", {11'h0, bus.err_o}, 12'h1);

    // Asynchronous reset in the middle of DRIVE.
    latch(8'h42, 4'h2);
    push(EvRomRd, 12'h242, 8'h00);
    push(EvDrive, 12'h000, 8'h5C);
    bus.psen_n_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_dir_before", {11'h0, bus.db_dir_o}, 12'h1);
    #2;
    res = 1'b1;
    #1;
    chk("rst_mid_dir", {11'h0, bus.db_dir_o}, 12'h0);
    chk("rst_mid_db", {4'h0, bus.db_o}, 12'h0FF);
    chk("rst_mid_err", {11'h0, bus.err_o}, 12'h0);
    chk("rst_mid_addr", bus.rom_addr_o, 12'h000);
    bus.psen_n_i = 1'b1;
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);

    // RD and WR fall on the same edge: error, no requests.
    bus.rd_n_i = 1'b0;
    bus.wr_n_i = 1'b0;
    @(negedge clk);
    chk("multi_err", {11'h0, bus.err_o}, 12'h1);
    chk("multi_pulses", {10'h0, bus.ram_rd_o, bus.ram_we_o}, 12'h0);
    @(negedge clk);
    bus.rd_n_i = 1'b1;
    bus.wr_n_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("multi_no_we", {11'h0, bus.ram_we_o}, 12'h0);
    chk("multi_dir", {11'h0, bus.db_dir_o}, 12'h0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 12'(sb.size()), 12'h000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
